// File: rtl/mpu_store_serializer_if.sv
// Store-side bus of the MPU matrix register file reader: request handshake,
// register-file address/data, and the element stream toward writeback.
interface mpu_store_serializer_if;
    localparam int FP              = 32;
    localparam int M               = 3;
    localparam int N               = 3;
    localparam int MBITS           = 2;
    localparam int NBITS           = 2;
    localparam int MATRIX_REG_SIZE = 2;

    logic                              store_req;
    logic [MATRIX_REG_SIZE-1:0]        store_addr;
    logic                              store_ready;
    logic [MATRIX_REG_SIZE-1:0]        reg_store_addr;
    logic [M-1:0][N-1:0][FP-1:0]       matrix_in;
    logic                              elem_valid;
    logic                              elem_ready;
    logic [FP-1:0]                     elem_out;
    logic [MBITS:0]                    elem_m;
    logic [NBITS:0]                    elem_n;
    logic                              elem_last;
    logic                              store_done;

    // Serializer side
    modport master (
        input  store_req, store_addr, matrix_in, elem_ready,
        output store_ready, reg_store_addr, elem_valid, elem_out,
               elem_m, elem_n, elem_last, store_done
    );

    // Register file / requester / downstream side
    modport slave (
        output store_req, store_addr, matrix_in, elem_ready,
        input  store_ready, reg_store_addr, elem_valid, elem_out,
               elem_m, elem_n, elem_last, store_done
    );
endinterface

// File: rtl/mpu_store_serializer.sv
// Reads one matrix register out of the register file, snapshots it into a
// local buffer, and streams it element by element in row-major order.
module mpu_store_serializer #(
    parameter int READ_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    mpu_store_serializer_if.master  bus
);
    localparam int FP              = 32;
    localparam int M               = 3;
    localparam int N               = 3;
    localparam int MBITS           = 2;
    localparam int NBITS           = 2;
    localparam int MATRIX_REG_SIZE = 2;
    localparam int NE              = M * N;
    localparam int IW              = $clog2(NE);
    localparam int MW              = MBITS + 1;
    localparam int NW              = NBITS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_STREAM
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [2:0]                 r_wait;
    logic [MATRIX_REG_SIZE-1:0] r_addr;
    logic [MW-1:0]              r_m;
    logic [NW-1:0]              r_n;
    logic [IW-1:0]              r_idx;
    logic                       r_done;
    logic [FP-1:0]              r_buf [NE];

    logic                       w_stream;
    logic                       w_hs;
    logic                       w_at_last;
    logic [NE-1:0][FP-1:0]      w_mat;

    // Packed [m][n] layout flattens to linear index m*N+n
    assign w_mat     = bus.matrix_in;
    assign w_stream  = (r_state == S_STREAM);
    assign w_hs      = w_stream & bus.elem_ready;
    assign w_at_last = (r_idx == IW'(NE - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.store_req) w_state_next = S_FETCH;
            S_FETCH:  if (r_wait == 3'(READ_LAT - 1)) w_state_next = S_LATCH;
            S_LATCH:  w_state_next = S_STREAM;
            S_STREAM: if (w_hs && w_at_last) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Address latch, read-latency counter, element indices and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
            r_addr <= '0;
            r_m    <= '0;
            r_n    <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.store_req) begin
                        r_addr <= bus.store_addr;
                        r_wait <= '0;
                    end
                end
                S_FETCH: r_wait <= r_wait + 3'd1;
                S_LATCH: begin
                    r_m   <= '0;
                    r_n   <= '0;
                    r_idx <= '0;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        if (w_at_last) begin
                            r_done <= 1'b1;
                            r_m    <= '0;
                            r_n    <= '0;
                            r_idx  <= '0;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                            if (r_n == NW'(N - 1)) begin
                                r_n <= '0;
                                r_m <= r_m + MW'(1);
                            end else begin
                                r_n <= r_n + NW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Snapshot the whole matrix in the latch cycle; later register-file
    // writes cannot disturb the stream
    generate
        for (genvar gi = 0; gi < NE; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (r_state == S_LATCH) r_buf[gi] <= w_mat[gi];
            end
        end
    endgenerate

    assign bus.store_ready    = (r_state == S_IDLE);
    assign bus.reg_store_addr = r_addr;
    assign bus.elem_valid     = w_stream;
    assign bus.elem_out       = w_stream ? r_buf[r_idx] : '0;
    assign bus.elem_m         = r_m;
    assign bus.elem_n         = r_n;
    assign bus.elem_last      = w_stream & w_at_last;
    assign bus.store_done     = r_done;
endmodule

// File: tb/tb_mpu_store_serializer.sv
// Bench for mpu_store_serializer: directed scenarios with hand-computed
// expectations plus a randomized phase, all checked against a
// transaction-level model of the serializer.
module tb_mpu_store_serializer;
    localparam int RL = 1;
    localparam int NE = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpu_store_serializer_if bus();

    mpu_store_serializer #(.READ_LAT(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    logic [31:0] regs [4][NE];
    logic [31:0] ftab [NE] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000,
                               32'h40E00000, 32'h41000000, 32'h41100000};

    // Register file with one cycle of read latency
    always @(posedge clk) begin
        for (int i = 0; i < NE; i++)
            bus.matrix_in[i/3][i%3] <= regs[bus.reg_store_addr][i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a request snapshots the register, the stream
    // starts RL+2 cycles after acceptance, one element per handshake
    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    int          m_idx  = 0;
    logic [1:0]  m_addr = '0;
    logic        m_done = 1'b0;
    logic [31:0] m_snap [NE];

    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = m_busy && (m_cnt >= RL + 2);
        if (chk_en) begin
            chk("store_ready", 32'(bus.store_ready), 32'(!m_busy));
            chk("elem_valid", 32'(bus.elem_valid), 32'(exp_valid));
            chk("store_done", 32'(bus.store_done), 32'(m_done));
            chk("reg_store_addr", 32'(bus.reg_store_addr), 32'(m_addr));
            if (exp_valid) begin
                chk("elem_out", bus.elem_out, m_snap[m_idx]);
                chk("elem_m", 32'(bus.elem_m), 32'(m_idx / 3));
                chk("elem_n", 32'(bus.elem_n), 32'(m_idx % 3));
                chk("elem_last", 32'(bus.elem_last), 32'(m_idx == NE - 1));
            end
        end
        m_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_addr = '0;
            m_idx  = 0;
        end else if (!m_busy) begin
            if (bus.store_req) begin
                m_busy = 1'b1;
                m_cnt  = 1;
                m_idx  = 0;
                m_addr = bus.store_addr;
                for (int i = 0; i < NE; i++) m_snap[i] = regs[bus.store_addr][i];
            end
        end else begin
            if (exp_valid && bus.elem_ready) begin
                if (m_idx == NE - 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_idx++;
                end
            end
            if (m_cnt < 100) m_cnt++;
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!bus.store_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(bus.store_ready), 32'd1);
    endtask

    // mode 1: plain stream, 2: alternating ready, 3: stray requests,
    // 4: register write mid-stream, 5: reset mid-stream, 6: back-to-back
    task automatic directed(input int mode);
        logic [31:0] got [$];
        got = {};
        @(posedge clk); #1;
        bus.store_req  = 1'b1;
        bus.store_addr = 2'd2;
        bus.elem_ready = 1'b1;
        @(posedge clk); #1;                       // edge 0 has passed
        bus.store_req = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (mode == 2) bus.elem_ready = k[0];
            if (mode == 3) begin
                bus.store_req  = (k == 1 || k == 7);
                bus.store_addr = 2'd1;
            end
            if (mode == 4 && k == 5) regs[2][8] = 32'h42C60000;
            if (mode == 5) rst = (k == 6);
            if (mode == 6) begin
                bus.store_req  = (k == 12);
                bus.store_addr = 2'd0;
            end
            @(negedge clk);
            if (bus.elem_valid && bus.elem_ready) got.push_back(bus.elem_out);
            if (mode == 1) begin
                if (k == 1) chk("t1_rsa_c1", 32'(bus.reg_store_addr), 32'd2);
                if (k == 3) begin
                    chk("t1_first", bus.elem_out, 32'h3F800000);
                    chk("t1_first_mn", {bus.elem_m, bus.elem_n}, 32'd0);
                end
                if (k >= 3 && k <= 10) chk("t1_notlast", 32'(bus.elem_last), 32'd0);
                if (k == 11) begin
                    chk("t1_last_val", bus.elem_out, 32'h41100000);
                    chk("t1_last_flag", 32'(bus.elem_last), 32'd1);
                    chk("t1_last_mn", {bus.elem_m, bus.elem_n}, {26'd0, 3'd2, 3'd2});
                end
                if (k == 12) begin
                    chk("t1_done", 32'(bus.store_done), 32'd1);
                    chk("t1_ready_back", 32'(bus.store_ready), 32'd1);
                end
                if (k == 13) chk("t1_done_pulse", 32'(bus.store_done), 32'd0);
            end
            if (mode == 3 && (k == 1 || k == 7))
                chk("t3_busy", 32'(bus.store_ready), 32'd0);
            if (mode == 3 && k == 11) chk("t3_last", bus.elem_out, 32'h41100000);
            if (mode == 4 && k == 11) chk("t4_isolated", bus.elem_out, 32'h41100000);
            if (mode == 5 && k == 7) begin
                chk("t5_valid", 32'(bus.elem_valid), 32'd0);
                chk("t5_ready", 32'(bus.store_ready), 32'd1);
            end
            if (mode == 5 && k >= 7) chk("t5_nodone", 32'(bus.store_done), 32'd0);
            if (mode == 6 && k == 12) chk("t6_done", 32'(bus.store_done), 32'd1);
            if (mode == 6 && k == 15) begin
                chk("t6_valid", 32'(bus.elem_valid), 32'd1);
                chk("t6_first", bus.elem_out, regs[0][0]);
                chk("t6_rsa", 32'(bus.reg_store_addr), 32'd0);
            end
            @(posedge clk); #1;
        end
        bus.store_req  = 1'b0;
        bus.elem_ready = 1'b1;
        rst            = 1'b0;
        if (mode == 2) begin
            chk("t2_count", 32'(got.size()), 32'd9);
            for (int i = 0; i < NE && i < got.size(); i++)
                chk("t2_order", got[i], ftab[i]);
        end
        if (mode == 4) regs[2][8] = ftab[8];
        wait_idle("idle_after_directed");
    endtask

    initial begin
        bus.store_req  = 1'b0;
        bus.store_addr = '0;
        bus.elem_ready = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < NE; i++)
                regs[r][i] = (r == 2) ? ftab[i] : {8'(r + 1), 24'(i * 16 + 7)};
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.store_ready), 32'd1);
        chk("rst_valid", 32'(bus.elem_valid), 32'd0);
        chk("rst_last", 32'(bus.elem_last), 32'd0);
        chk("rst_done", 32'(bus.store_done), 32'd0);
        chk("rst_rsa", 32'(bus.reg_store_addr), 32'd0);
        chk("rst_out", bus.elem_out, 32'd0);
        chk("rst_mn", {bus.elem_m, bus.elem_n}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int mode = 1; mode <= 6; mode++) directed(mode);
        directed(1);                             // fresh stream after the reset test

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst            = ($urandom_range(0, 199) == 0);
            bus.store_req  = ($urandom_range(0, 3) == 0);
            bus.store_addr = 2'($urandom_range(0, 3));
            bus.elem_ready = ($urandom_range(0, 2) != 0);
            if ((!m_busy || m_cnt >= RL + 2) && $urandom_range(0, 3) == 0)
                regs[$urandom_range(0, 3)][$urandom_range(0, NE - 1)] = $urandom;
        end
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.store_req = 1'b0;
        bus.elem_ready = 1'b1;
        wait_idle("idle_after_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
